// File: rtl/rv_mem_seq_ctrl_if.sv
`default_nettype none
//============================================================================
// Module      : rv_mem_seq_ctrl_if
// Description : Instruction- and data-memory handshake bundle between the
//               RV64 memory sequencer (master) and the external memories
//               (slave). Signal directions are named from the sequencer side.
// Revision    : 1.0 - initial release
//============================================================================
interface rv_mem_seq_ctrl_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
);
   // Instruction memory channel
   logic              out_imem_req;
   logic [XLEN-1:0]   out_imem_addr;
   logic              in_imem_gnt;
   logic              in_imem_rvalid;
   logic [ILEN-1:0]   in_imem_rdata;

   // Data memory channel
   logic              out_dmem_req;
   logic              out_dmem_we;
   logic [XLEN-1:0]   out_dmem_addr;
   logic [XLEN-1:0]   out_dmem_wdata;
   logic [XLEN/8-1:0] out_dmem_strb;
   logic              in_dmem_gnt;
   logic              in_dmem_rvalid;
   logic [XLEN-1:0]   in_dmem_rdata;

   modport master (
      output out_imem_req, out_imem_addr,
      input  in_imem_gnt, in_imem_rvalid, in_imem_rdata,
      output out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wdata, out_dmem_strb,
      input  in_dmem_gnt, in_dmem_rvalid, in_dmem_rdata
   );

   modport slave (
      input  out_imem_req, out_imem_addr,
      output in_imem_gnt, in_imem_rvalid, in_imem_rdata,
      input  out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wdata, out_dmem_strb,
      output in_dmem_gnt, in_dmem_rvalid, in_dmem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/rv_mem_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module      : rv_mem_seq_ctrl
// Description : Multi-cycle memory sequencer for an RV64 core. Runs the
//               fetch / execute / data-access handshakes against external
//               instruction and data memories, latches the fetched
//               instruction and load data, and emits a one-cycle commit
//               pulse that gates PC and register-file updates.
//               Optional macro RV_MEM_TIMEOUT_EN adds a per-phase wait
//               timeout that aborts the handshake and flags out_bus_err.
// Revision    : 1.0 - initial release
//============================================================================
module rv_mem_seq_ctrl #(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              in_Clk,
   input  logic              in_Rst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              in_ld_req,
   input  logic              in_st_req,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wr_data,
   input  logic [XLEN/8-1:0] in_wr_strb,
   output logic [ILEN-1:0]   out_inst,
   output logic [XLEN-1:0]   out_ld_data,
   output logic              out_commit,
   output logic              out_busy,
   output logic              out_bus_err,
   rv_mem_seq_ctrl_if.master mem
);

   // Instruction substituted when a fetch is abandoned (addi x0,x0,0)
   localparam logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_F_REQ  = 3'd1,
      ST_F_WAIT = 3'd2,
      ST_EXEC   = 3'd3,
      ST_D_REQ  = 3'd4,
      ST_D_WAIT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [ILEN-1:0]   inst_q, inst_d;
   logic [XLEN-1:0]   ld_data_q, ld_data_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   daddr_q, daddr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN/8-1:0] strb_q, strb_d;
   logic              commit_q, commit_d;
   logic              bus_err_q, bus_err_d;
   logic              w_enter;     // a handshake state is (re)entered next cycle
   logic              w_timeout;   // current wait phase has used up its budget

`ifdef RV_MEM_TIMEOUT_EN
   // Counter is at least 8 bits, at most 16, otherwise just wide enough for TIMEOUT
   localparam int CW_RAW = $clog2(TIMEOUT + 1);
   localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

   logic [CW-1:0] cnt_q, cnt_d;

   // Fires in the last allowed wait cycle, so the abort lands when the count hits TIMEOUT
   assign w_timeout = (cnt_q == CW'(TIMEOUT - 1));
   assign cnt_d     = w_enter ? '0 : cnt_q + 1'b1;

   // Wait-cycle counter, cleared whenever a handshake state is entered
   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Without the timeout the sequencer waits on the memories indefinitely
   assign w_timeout = 1'b0;
`endif

   // Next-state, latch and commit decisions for the handshake sequencer
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      ld_data_d = ld_data_q;
      we_d      = we_q;
      daddr_d   = daddr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      commit_d  = 1'b0;
      bus_err_d = 1'b0;
      w_enter   = 1'b0;

      case (state_q)
         ST_RST: begin
            state_d = ST_F_REQ;
         end

         ST_F_REQ: begin
            if (mem.in_imem_gnt) begin
               if (mem.in_imem_rvalid) begin
                  inst_d  = mem.in_imem_rdata;
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_F_WAIT;
               end
            end else if (w_timeout) begin
               inst_d    = NOP_INST;
               commit_d  = 1'b1;
               bus_err_d = 1'b1;
               w_enter   = 1'b1;
            end
         end

         ST_F_WAIT: begin
            if (mem.in_imem_rvalid) begin
               inst_d  = mem.in_imem_rdata;
               state_d = ST_EXEC;
            end else if (w_timeout) begin
               inst_d    = NOP_INST;
               commit_d  = 1'b1;
               bus_err_d = 1'b1;
               state_d   = ST_F_REQ;
            end
         end

         ST_EXEC: begin
            if (in_ld_req || in_st_req) begin
               // Load wins when both are decoded
               we_d    = ~in_ld_req;
               daddr_d = in_addr;
               wdata_d = in_wr_data;
               strb_d  = in_wr_strb;
               state_d = ST_D_REQ;
            end else begin
               commit_d = 1'b1;
               state_d  = ST_F_REQ;
            end
         end

         ST_D_REQ: begin
            if (mem.in_dmem_gnt) begin
               if (we_q) begin
                  commit_d = 1'b1;
                  state_d  = ST_F_REQ;
               end else if (mem.in_dmem_rvalid) begin
                  ld_data_d = mem.in_dmem_rdata;
                  commit_d  = 1'b1;
                  state_d   = ST_F_REQ;
               end else begin
                  state_d = ST_D_WAIT;
               end
            end else if (w_timeout) begin
               if (!we_q) begin
                  ld_data_d = '0;
               end
               commit_d  = 1'b1;
               bus_err_d = 1'b1;
               state_d   = ST_F_REQ;
            end
         end

         ST_D_WAIT: begin
            if (mem.in_dmem_rvalid) begin
               ld_data_d = mem.in_dmem_rdata;
               commit_d  = 1'b1;
               state_d   = ST_F_REQ;
            end else if (w_timeout) begin
               ld_data_d = '0;
               commit_d  = 1'b1;
               bus_err_d = 1'b1;
               state_d   = ST_F_REQ;
            end
         end

         default: begin
            state_d = ST_RST;
         end
      endcase

      if (state_d != state_q) begin
         w_enter = 1'b1;
      end

      // Fetch address is captured once per fetch and held until the grant
      if (w_enter && (state_d == ST_F_REQ)) begin
         pc_d = in_pc;
      end
   end

   // State and datapath-facing registers; reset clears everything at once
   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         state_q   <= ST_RST;
         pc_q      <= '0;
         inst_q    <= '0;
         ld_data_q <= '0;
         we_q      <= 1'b0;
         daddr_q   <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         commit_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         ld_data_q <= ld_data_d;
         we_q      <= we_d;
         daddr_q   <= daddr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         commit_q  <= commit_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Requests decode straight from state so reset removes them without a clock
   assign mem.out_imem_req   = (state_q == ST_F_REQ);
   assign mem.out_imem_addr  = pc_q;
   assign mem.out_dmem_req   = (state_q == ST_D_REQ);
   assign mem.out_dmem_we    = we_q;
   assign mem.out_dmem_addr  = daddr_q;
   assign mem.out_dmem_wdata = wdata_q;
   assign mem.out_dmem_strb  = strb_q;

   assign out_inst    = inst_q;
   assign out_ld_data = ld_data_q;
   assign out_commit  = commit_q;
   assign out_bus_err = bus_err_q;
   // Busy everywhere but EXEC, yet held low while reset is asserted
   assign out_busy    = (state_q != ST_EXEC) && !in_Rst;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_rv_mem_seq_ctrl
// Description : Self-checking bench for rv_mem_seq_ctrl. A vector table of
//               instructions with memory latencies is played through a
//               memory model; commits are checked against a scoreboard of
//               expected instruction / load data / error values. Extra
//               hand-written sequences cover reset mid-handshake and the
//               fetch-timeout path (RV_MEM_TIMEOUT_EN).
// Revision    : 1.0 - initial release
//============================================================================
module tb_rv_mem_seq_ctrl;

   localparam int          XLEN    = 64;
   localparam int          ILEN    = 32;
   localparam int          TIMEOUT = 4;
   localparam int          NV      = 9;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic              in_Clk = 1'b0;
   logic              in_Rst = 1'b1;
   logic [XLEN-1:0]   in_pc = '0;
   logic              in_ld_req = 1'b0;
   logic              in_st_req = 1'b0;
   logic [XLEN-1:0]   in_addr = '0;
   logic [XLEN-1:0]   in_wr_data = '0;
   logic [XLEN/8-1:0] in_wr_strb = '0;
   logic [ILEN-1:0]   out_inst;
   logic [XLEN-1:0]   out_ld_data;
   logic              out_commit;
   logic              out_busy;
   logic              out_bus_err;

   rv_mem_seq_ctrl_if #(.XLEN(XLEN), .ILEN(ILEN)) mem_if ();

   rv_mem_seq_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .TIMEOUT(TIMEOUT)) dut (
      .in_Clk      (in_Clk),
      .in_Rst      (in_Rst),
      .in_pc       (in_pc),
      .in_ld_req   (in_ld_req),
      .in_st_req   (in_st_req),
      .in_addr     (in_addr),
      .in_wr_data  (in_wr_data),
      .in_wr_strb  (in_wr_strb),
      .out_inst    (out_inst),
      .out_ld_data (out_ld_data),
      .out_commit  (out_commit),
      .out_busy    (out_busy),
      .out_bus_err (out_bus_err),
      .mem         (mem_if)
   );

   always #5 in_Clk = ~in_Clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [63:0] pc;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [31:0] inst;
      logic [63:0] rdata;
      int          ig;       // imem cycles before gnt
      int          ir;       // imem cycles from gnt to rvalid
      int          dg;       // dmem cycles before gnt
      int          dr;       // dmem cycles from gnt to rvalid (loads)
      logic        exp_we;
      logic [63:0] exp_ld;   // out_ld_data expected at commit
      int          exp_cyc;  // cycles from fetch start to next fetch start
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] ld;
      logic        err;
   } exp_t;

   vec_t vecs [NV];
   exp_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cycle   = 0;

   function automatic vec_t mk(input logic ld, input logic st, input logic [63:0] pc,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] strb, input logic [31:0] inst,
                               input logic [63:0] rdata, input int ig, input int ir,
                               input int dg, input int dr, input logic exp_we,
                               input logic [63:0] exp_ld, input int exp_cyc);
      vec_t v;
      v.ld = ld; v.st = st; v.pc = pc; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.inst = inst; v.rdata = rdata; v.ig = ig; v.ir = ir; v.dg = dg; v.dr = dr;
      v.exp_we = exp_we; v.exp_ld = exp_ld; v.exp_cyc = exp_cyc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Advance one cycle to the next falling edge and retire any commit against the scoreboard
   task automatic tick();
      exp_t e;
      @(negedge in_Clk);
      cycle++;
      if (out_commit === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_commit: unexpected commit at cycle %0d with empty queue", cycle);
         end else begin
            e = sb.pop_front();
            chk("sb_inst", 64'(out_inst), 64'(e.inst));
            chk("sb_ld_data", out_ld_data, e.ld);
            chk("sb_bus_err", 64'(out_bus_err), 64'(e.err));
         end
      end
   endtask

   task automatic clr_mem();
      mem_if.in_imem_gnt    = 1'b0;
      mem_if.in_imem_rvalid = 1'b0;
      mem_if.in_dmem_gnt    = 1'b0;
      mem_if.in_dmem_rvalid = 1'b0;
   endtask

   // Play one table entry; entered and left on a falling edge with the DUT in F_REQ
   task automatic run_vec(input int k);
      vec_t v;
      int   t0;
      v  = vecs[k];
      t0 = cycle;
      chk("f_req", 64'(mem_if.out_imem_req), 64'd1);
      chk("f_addr", mem_if.out_imem_addr, v.pc);
      chk("f_busy", 64'(out_busy), 64'd1);
      in_pc      = (k + 1 < NV) ? vecs[k+1].pc : 64'h8000;
      in_ld_req  = v.ld;
      in_st_req  = v.st;
      in_addr    = v.addr;
      in_wr_data = v.wdata;
      in_wr_strb = v.strb;

      for (int i = 0; i < v.ig; i++) begin
         tick();
         chk("f_req_hold", 64'(mem_if.out_imem_req), 64'd1);
         chk("f_addr_hold", mem_if.out_imem_addr, v.pc);
      end
      mem_if.in_imem_gnt    = 1'b1;
      mem_if.in_imem_rvalid = (v.ir == 0);
      mem_if.in_imem_rdata  = (v.ir == 0) ? v.inst : 32'hBAD0_0BAD;
      tick();
      clr_mem();
      if (v.ir > 0) begin
         for (int i = 1; i < v.ir; i++) begin
            chk("f_wait_noreq", 64'(mem_if.out_imem_req), 64'd0);
            tick();
         end
         mem_if.in_imem_rvalid = 1'b1;
         mem_if.in_imem_rdata  = v.inst;
         tick();
         clr_mem();
      end

      // EXEC cycle
      chk("exec_busy", 64'(out_busy), 64'd0);
      chk("exec_inst", 64'(out_inst), 64'(v.inst));
      sb.push_back(exp_t'{v.inst, v.exp_ld, 1'b0});
      tick();

      if (v.ld || v.st) begin
         chk("d_req", 64'(mem_if.out_dmem_req), 64'd1);
         chk("d_we", 64'(mem_if.out_dmem_we), 64'(v.exp_we));
         chk("d_addr", mem_if.out_dmem_addr, v.addr);
         if (v.exp_we) begin
            chk("d_wdata", mem_if.out_dmem_wdata, v.wdata);
            chk("d_strb", 64'(mem_if.out_dmem_strb), 64'(v.strb));
         end
         for (int i = 0; i < v.dg; i++) begin
            tick();
            chk("d_req_hold", 64'(mem_if.out_dmem_req), 64'd1);
            chk("d_addr_hold", mem_if.out_dmem_addr, v.addr);
            if (v.exp_we) chk("d_strb_hold", 64'(mem_if.out_dmem_strb), 64'(v.strb));
         end
         mem_if.in_dmem_gnt = 1'b1;
         if (v.exp_we) begin
            // Stray rvalid alongside a store grant must not touch the load latch
            mem_if.in_dmem_rvalid = 1'b1;
            mem_if.in_dmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         end else begin
            mem_if.in_dmem_rvalid = (v.dr == 0);
            mem_if.in_dmem_rdata  = v.rdata;
         end
         tick();
         clr_mem();
         if (!v.exp_we && v.dr > 0) begin
            for (int i = 1; i < v.dr; i++) begin
               chk("d_wait_noreq", 64'(mem_if.out_dmem_req), 64'd0);
               chk("d_wait_nocommit", 64'(out_commit), 64'd0);
               tick();
            end
            mem_if.in_dmem_rvalid = 1'b1;
            mem_if.in_dmem_rdata  = v.rdata;
            tick();
            clr_mem();
         end
      end

      chk("commit", 64'(out_commit), 64'd1);
      chk("cycles", 64'(cycle - t0), 64'(v.exp_cyc));
      in_ld_req = 1'b0;
      in_st_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            ld    st    pc       addr     wdata    strb   inst          rdata                   ig ir dg dr we    exp_ld                  cyc
      vecs[0] = mk(1'b0, 1'b0, 64'h1000, 64'h0,   64'h0,   8'h00, 32'h0000_0013, 64'h0,                 0, 0, 0, 0, 1'b0, 64'h0,                  2);
      vecs[1] = mk(1'b0, 1'b0, 64'h1004, 64'h0,   64'h0,   8'h00, 32'h0010_0093, 64'h0,                 0, 0, 0, 0, 1'b0, 64'h0,                  2);
      vecs[2] = mk(1'b0, 1'b0, 64'h1008, 64'h0,   64'h0,   8'h00, 32'h00A0_0093, 64'h0,                 2, 3, 0, 0, 1'b0, 64'h0,                  7);
      vecs[3] = mk(1'b1, 1'b0, 64'h100C, 64'h2008, 64'h0,  8'h00, 32'h0081_3083, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 4, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 7);
      vecs[4] = mk(1'b0, 1'b1, 64'h1010, 64'h2010, 64'h1122_3344, 8'h0F, 32'h0011_3423, 64'h0,          0, 0, 2, 0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 5);
      vecs[5] = mk(1'b1, 1'b0, 64'h1014, 64'h3001, 64'h0,  8'h00, 32'h0011_3103, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 3);
      vecs[6] = mk(1'b1, 1'b1, 64'h1018, 64'h4000, 64'hFFFF, 8'hFF, 32'h0002_3183, 64'h55AA,             0, 0, 1, 0, 1'b0, 64'h55AA,               4);
      vecs[7] = mk(1'b0, 1'b1, 64'h101C, 64'h5000, 64'hA5A5, 8'h80, 32'h0032_3023, 64'h0,                0, 0, 0, 0, 1'b1, 64'h55AA,               3);
      vecs[8] = mk(1'b0, 1'b0, 64'h1020, 64'h0,   64'h0,   8'h00, 32'h0020_8113, 64'h0,                 0, 2, 0, 0, 1'b0, 64'h55AA,               4);

      clr_mem();
      mem_if.in_imem_rdata = 32'hFFFF_FFFF;
      mem_if.in_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;

      // Reset held for three cycles: every output low
      in_pc = vecs[0].pc;
      for (int i = 0; i < 3; i++) tick();
      chk("rst_inst", 64'(out_inst), 64'd0);
      chk("rst_ld_data", out_ld_data, 64'd0);
      chk("rst_commit", 64'(out_commit), 64'd0);
      chk("rst_busy", 64'(out_busy), 64'd0);
      chk("rst_imem_req", 64'(mem_if.out_imem_req), 64'd0);
      chk("rst_dmem_req", 64'(mem_if.out_dmem_req), 64'd0);
      chk("rst_bus_err", 64'(out_bus_err), 64'd0);
      in_Rst = 1'b0;
      tick();

      for (int k = 0; k < NV; k++) run_vec(k);

      // Reset during D_WAIT: everything drops without a clock, then a fresh fetch
      chk("r_freq", 64'(mem_if.out_imem_req), 64'd1);
      in_ld_req             = 1'b1;
      in_addr               = 64'h6000;
      mem_if.in_imem_gnt    = 1'b1;
      mem_if.in_imem_rvalid = 1'b1;
      mem_if.in_imem_rdata  = 32'h0101_3283;
      tick();
      clr_mem();
      chk("r_exec_busy", 64'(out_busy), 64'd0);
      tick();
      chk("r_dreq", 64'(mem_if.out_dmem_req), 64'd1);
      mem_if.in_dmem_gnt = 1'b1;
      tick();
      clr_mem();
      in_ld_req = 1'b0;
      chk("r_dwait_busy", 64'(out_busy), 64'd1);
      in_pc = 64'h8000;
      #2 in_Rst = 1'b1;
      #1;
      chk("r_async_dmem_req", 64'(mem_if.out_dmem_req), 64'd0);
      chk("r_async_commit", 64'(out_commit), 64'd0);
      chk("r_async_busy", 64'(out_busy), 64'd0);
      chk("r_async_inst", 64'(out_inst), 64'd0);
      chk("r_async_ld_data", out_ld_data, 64'd0);
      sb.delete();
      tick();
      tick();
      in_Rst                = 1'b0;
      mem_if.in_dmem_rvalid = 1'b1;   // late rvalid from the aborted load
      mem_if.in_dmem_rdata  = 64'h1234_5678_9ABC_DEF0;
      tick();
      clr_mem();
      chk("r_first_is_fetch", 64'(mem_if.out_imem_req), 64'd1);
      chk("r_no_dmem_req", 64'(mem_if.out_dmem_req), 64'd0);
      chk("r_fetch_addr", mem_if.out_imem_addr, 64'h8000);
      chk("r_ld_data_kept", out_ld_data, 64'd0);

`ifdef RV_MEM_TIMEOUT_EN
      // Fetch never granted: abort after TIMEOUT wait cycles with NOP and error
      sb.push_back(exp_t'{NOP, 64'h0, 1'b1});
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         tick();
         chk("to_req_hold", 64'(mem_if.out_imem_req), 64'd1);
         chk("to_no_commit", 64'(out_commit), 64'd0);
      end
      tick();
      chk("to_commit", 64'(out_commit), 64'd1);
      chk("to_bus_err", 64'(out_bus_err), 64'd1);
      chk("to_inst_nop", 64'(out_inst), 64'(NOP));
`else
      // No timeout: an ungranted fetch waits indefinitely with no error
      for (int i = 0; i < 20; i++) tick();
      chk("nto_req_hold", 64'(mem_if.out_imem_req), 64'd1);
      chk("nto_addr_hold", mem_if.out_imem_addr, 64'h8000);
      chk("nto_bus_err", 64'(out_bus_err), 64'd0);
      chk("nto_no_commit", 64'(out_commit), 64'd0);
      mem_if.in_imem_gnt    = 1'b1;
      mem_if.in_imem_rvalid = 1'b1;
      mem_if.in_imem_rdata  = NOP;
      tick();
      clr_mem();
      sb.push_back(exp_t'{NOP, 64'h0, 1'b0});
      tick();
      chk("nto_commit", 64'(out_commit), 64'd1);
`endif

      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_mem_seq_ctrl.md
Name: rv_mem_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer that sits between the RV64 datapath/control unit and external instruction and data memories.
- Replaces the single-cycle, zero-wait memory assumption with request/grant/rvalid handshakes on both memories.
- Inserts wait states, latches the fetched instruction and load data, and issues a one-cycle commit pulse that gates PC and register-file updates.

Parameters:
- XLEN, 64, datapath and address width (32 or 64).
- ILEN, 32, instruction width.
- TIMEOUT, 255, maximum wait cycles per handshake phase; used only with RV_MEM_TIMEOUT_EN.

Ports:
- in_Clk  input  1  clock, rising edge.
- in_Rst  input  1  asynchronous, active-high reset.
- in_pc  input  XLEN  current PC from the datapath.
- in_ld_req  input  1  decoded load in the current instruction; sampled in EXEC only.
- in_st_req  input  1  decoded store in the current instruction; sampled in EXEC only.
- in_addr  input  XLEN  data address from the ALU.
- in_wr_data  input  XLEN  store data.
- in_wr_strb  input  XLEN/8  store byte enables.
- out_inst  output  ILEN  latched instruction to the decoder.
- out_ld_data  output  XLEN  latched load data.
- out_commit  output  1  one-cycle pulse; PC and register file update only on this pulse.
- out_busy  output  1  high in every state except EXEC.
- out_imem_req  output  1  instruction fetch request.
- out_imem_addr  output  XLEN  fetch address.
- in_imem_gnt  input  1  fetch request accepted.
- in_imem_rvalid  input  1  fetch data valid.
- in_imem_rdata  input  ILEN  fetch data.
- out_dmem_req  output  1  data memory request.
- out_dmem_we  output  1  1 = store, 0 = load.
- out_dmem_addr  output  XLEN  data address.
- out_dmem_wdata  output  XLEN  store data.
- out_dmem_strb  output  XLEN/8  store byte enables.
- in_dmem_gnt  input  1  data request accepted.
- in_dmem_rvalid  input  1  load data valid.
- in_dmem_rdata  input  XLEN  load data.
- out_bus_err  output  1  timeout error pulse; tied to 0 without RV_MEM_TIMEOUT_EN.

Behaviour:
- Reset: in_Rst=1 forces state RST, immediately and regardless of the clock.
  - Forces every output to 0, including out_inst and out_ld_data.
  - Reset mid-handshake drops the request; there is no replay.
- States and transitions:
  - RST: goes to F_REQ on the first clock edge after reset release; out_busy=1.
  - F_REQ:
    - out_imem_req=1; out_imem_addr=in_pc, registered on entry and held stable until gnt.
    - On gnt with rvalid in the same cycle: latch rdata, go to EXEC.
    - On gnt without rvalid: go to F_WAIT.
  - F_WAIT: on rvalid, latch rdata into out_inst and go to EXEC. Extra rvalids in any other state are ignored.
  - EXEC:
    - Sample in_ld_req and in_st_req.
    - Neither set: out_commit=1, go to F_REQ.
    - Load: go to D_REQ with we=0. Load has priority if both are set.
    - Store: go to D_REQ with we=1.
    - Register addr, wdata and strb on exit.
  - D_REQ:
    - out_dmem_req=1 until gnt.
    - Store: on gnt, out_commit=1 and go to F_REQ; rvalid is not awaited.
    - Load with gnt and rvalid in the same cycle: latch data, out_commit=1, go to F_REQ.
    - Load with gnt only: go to D_WAIT.
  - D_WAIT: on rvalid, latch rdata into out_ld_data, out_commit=1, go to F_REQ.
- Commit timing:
  - out_commit is registered alongside the state transition.
  - It is high for exactly one cycle per instruction, in the cycle after the completing handshake.
  - The datapath writes PC and registers at the end of that cycle.
- Latency with zero-wait memory (gnt and rvalid in the same cycle as req):
  - ALU instruction: 3 cycles (F_REQ, EXEC, commit cycle in F_REQ of the next fetch, overlapped) = 2-cycle throughput.
  - Load or store: 3-cycle throughput.
- Stability rules:
  - out_inst stays stable from entry into EXEC until the next fetch's rvalid.
  - out_ld_data holds its last value until the next load.
- Width: XLEN=32 gives 4-bit strobes. No alignment checking; misaligned addresses pass through unchanged.

Optional Feature:
- Macro: RV_MEM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter, sized by TIMEOUT, clears on entry to F_REQ, F_WAIT, D_REQ and D_WAIT and increments each cycle spent waiting.
  - When it reaches TIMEOUT, drop the request, pulse out_bus_err together with out_commit, and go to F_REQ.
  - A fetch timeout sets out_inst to 32'h00000013 (NOP).
  - A load timeout sets out_ld_data to 0.
- Undefined: no counter; the block waits indefinitely; out_bus_err is a constant 0.

Test Plan:
- Reset 3 cycles, then zero-wait memory, ALU instruction at in_pc=0x1000 -> out_imem_addr=0x1000 in the first cycle, out_commit pulse every 2 cycles, out_busy=0 only in EXEC.
- Fetch with gnt after 2 cycles and rvalid 3 cycles later, rdata=0x00A00093 -> out_inst=0x00A00093 in EXEC; out_imem_addr held for all 3 request cycles.
- Load at in_addr=0x2008, dmem rvalid 4 cycles after gnt, rdata=0xDEADBEEF_CAFEF00D -> out_ld_data matches; exactly one commit, after rvalid.
- Store with in_wr_strb=0x0F, in_wr_data=0x11223344 -> out_dmem_we=1 and strb=0x0F held until gnt; commit in the cycle after gnt with no rvalid needed.
- in_Rst asserted during D_WAIT -> out_dmem_req and out_commit drop to 0 asynchronously; after release the first request is a fetch.
- With RV_MEM_TIMEOUT_EN and TIMEOUT=4, imem_gnt never asserted -> out_bus_err and out_commit pulse after 4 wait cycles; out_inst=0x00000013.
